// File: rtl/xfer_pkg.sv
// Shared types and default sizing for the deserializer-to-queue sequencer.
package xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENQ,
        DEQ,
        SETTLE,
        ACK
    } xfer_state_t;

    localparam int DEPTH_DEF       = 8;
    localparam int LEN_W_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchronizer for a single-bit signal crossing into this clock domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/xfer_sequencer.sv
// Serializes deserializer enqueues and user dequeues onto the queue, with a
// 4-phase ready/ack handshake toward the deserializer and full/empty gating.
module xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             des_ready_in,
    input  logic [7:0]       des_data_in,
    output logic             des_ack_out,
    input  logic             deq_req_in,
    input  logic [LEN_W-1:0] q_len_in,
    output logic [7:0]       q_data_out,
    output logic             q_enqueue_out,
    output logic             q_dequeue_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             deq_err_out,
    output logic             busy_out
);

    xfer_state_t state;
    xfer_state_t state_nxt;

    logic rdy_s;
    logic deq_pend;
    logic last_was_enq;
    logic enq_ok;
    logic load_data;
    logic reject;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_rdy_sync (
        .clock(clock),
        .reset(reset),
        .d    (des_ready_in),
        .q    (rdy_s)
    );

    assign full_out  = (q_len_in == LEN_W'(DEPTH));
    assign empty_out = (q_len_in == '0);
    assign enq_ok    = rdy_s && !full_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new request in the same cycle as a clear re-arms the pending flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deq_pend     <= 1'b0;
            last_was_enq <= 1'b0;
            deq_err_out  <= 1'b0;
            q_data_out   <= 8'h00;
        end else begin
            deq_pend    <= (deq_pend && !((state == DEQ) || reject)) || deq_req_in;
            deq_err_out <= reject;
            if (state == ENQ) begin
                last_was_enq <= 1'b1;
            end else if (state == DEQ) begin
                last_was_enq <= 1'b0;
            end
            if (load_data) begin
                q_data_out <= des_data_in;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        load_data     = 1'b0;
        reject        = 1'b0;
        des_ack_out   = 1'b0;
        q_enqueue_out = 1'b0;
        q_dequeue_out = 1'b0;
        busy_out      = 1'b1;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                // Round-robin: a pending dequeue wins contention only right after an enqueue.
                if (deq_pend && (!enq_ok || last_was_enq)) begin
                    if (empty_out) begin
                        reject = 1'b1;
                    end else begin
                        state_nxt = DEQ;
                    end
                end else if (enq_ok) begin
                    load_data = 1'b1;
                    state_nxt = ENQ;
                end
            end
            ENQ: begin
                q_enqueue_out = 1'b1;
                state_nxt     = SETTLE;
            end
            DEQ: begin
                q_dequeue_out = 1'b1;
                state_nxt     = SETTLE;
            end
            SETTLE: begin
                state_nxt = last_was_enq ? ACK : IDLE;
            end
            ACK: begin
                des_ack_out = 1'b1;
                if (!rdy_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xfer_sequencer.sv
// Self-checking bench for xfer_sequencer: full/empty vector table plus
// cycle-exact handshake, backpressure, arbitration and reset sequences.
module tb_xfer_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       des_ready_in = 1'b0;
    logic [7:0] des_data_in = 8'h00;
    logic       deq_req_in = 1'b0;
    logic [3:0] q_len_in = 4'd0;
    logic       des_ack_out;
    logic [7:0] q_data_out;
    logic       q_enqueue_out;
    logic       q_dequeue_out;
    logic       full_out;
    logic       empty_out;
    logic       deq_err_out;
    logic       busy_out;

    xfer_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .des_ready_in (des_ready_in),
        .des_data_in  (des_data_in),
        .des_ack_out  (des_ack_out),
        .deq_req_in   (deq_req_in),
        .q_len_in     (q_len_in),
        .q_data_out   (q_data_out),
        .q_enqueue_out(q_enqueue_out),
        .q_dequeue_out(q_dequeue_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .deq_err_out  (deq_err_out),
        .busy_out     (busy_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] len;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int failures = 0;
    int enq_count = 0;
    int deq_count = 0;
    int overlap_cnt = 0;
    int wide_cnt = 0;
    logic prev_enq = 1'b0;
    logic prev_deq = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Output monitor: records every enqueued byte and strobe-shape violations.
    always @(negedge clock) begin
        if (reset) begin
            if (q_enqueue_out) begin
                enq_count++;
                obs_q.push_back(q_data_out);
            end
            if (q_dequeue_out) deq_count++;
            if (q_enqueue_out && q_dequeue_out) overlap_cnt++;
            if ((q_enqueue_out && prev_enq) || (q_dequeue_out && prev_deq)) wide_cnt++;
        end
        prev_enq = q_enqueue_out;
        prev_deq = q_dequeue_out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        logic [7:0] o;
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_enq: got=%0h expected=none", name, o);
            end else begin
                chk({name, "_data"}, o, exp_q.pop_front());
            end
        end
        chk({name, "_missing_enq"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ack(input logic level, input int budget, input string name);
        int k;
        k = 0;
        while (des_ack_out !== level && k < budget) begin
            tick();
            k++;
        end
        chk(name, des_ack_out, level);
    endtask

    task automatic wait_deq(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (deq_count < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, deq_count, target);
    endtask

    task automatic finish_hs(input string name);
        wait_ack(1'b1, 10, {name, "_ack_hi"});
        des_ready_in = 1'b0;
        wait_ack(1'b0, 10, {name, "_ack_lo"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        logic ack_seen;

        vecs[0] = '{4'd0,  1'b0, 1'b1};
        vecs[1] = '{4'd1,  1'b0, 1'b0};
        vecs[2] = '{4'd7,  1'b0, 1'b0};
        vecs[3] = '{4'd8,  1'b1, 1'b0};
        vecs[4] = '{4'd9,  1'b0, 1'b0};
        vecs[5] = '{4'd15, 1'b0, 1'b0};

        repeat (2) @(negedge clock);
        chk("rst_busy", busy_out, 0);
        chk("rst_ack", des_ack_out, 0);
        chk("rst_enq", q_enqueue_out, 0);
        chk("rst_deq", q_dequeue_out, 0);
        chk("rst_err", deq_err_out, 0);
        chk("rst_data", q_data_out, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            q_len_in = vecs[i].len;
            #1;
            chk($sformatf("full_len%0d", vecs[i].len), full_out, vecs[i].full);
            chk($sformatf("empty_len%0d", vecs[i].len), empty_out, vecs[i].empty);
        end
        q_len_in = 4'd3;
        tick();

        // Single byte, cycle-exact
        des_data_in = 8'hA5;
        exp_q.push_back(8'hA5);
        des_ready_in = 1'b1;
        tick(); chk("sb_enq_c1", q_enqueue_out, 0);
        tick(); chk("sb_enq_c2", q_enqueue_out, 0);
        tick(); chk("sb_enq_c3", q_enqueue_out, 1);
        chk("sb_data", q_data_out, 8'hA5);
        chk("sb_busy", busy_out, 1);
        tick(); chk("sb_enq_c4", q_enqueue_out, 0);
        chk("sb_ack_c4", des_ack_out, 0);
        tick(); chk("sb_ack_c5", des_ack_out, 1);
        des_ready_in = 1'b0;
        tick(); chk("sb_ack_hold1", des_ack_out, 1);
        tick(); chk("sb_ack_hold2", des_ack_out, 1);
        tick(); chk("sb_ack_drop", des_ack_out, 0);
        chk("sb_idle", busy_out, 0);
        drain("sb");

        // Full backpressure
        q_len_in = 4'd8;
        des_data_in = 8'h3C;
        exp_q.push_back(8'h3C);
        base = enq_count;
        ack_seen = 1'b0;
        des_ready_in = 1'b1;
        repeat (20) begin
            tick();
            if (des_ack_out) ack_seen = 1'b1;
        end
        chk("bp_ack_withheld", ack_seen, 0);
        chk("bp_no_enq", enq_count - base, 0);
        chk("bp_busy", busy_out, 0);
        q_len_in = 4'd7;
        tick(); chk("bp_release_enq", q_enqueue_out, 1);
        finish_hs("bp");
        drain("bp");

        // Empty dequeue rejection
        q_len_in = 4'd0;
        base = deq_count;
        deq_req_in = 1'b1;
        tick(); deq_req_in = 1'b0;
        chk("ed_err_c1", deq_err_out, 0);
        tick(); chk("ed_err_c2", deq_err_out, 1);
        chk("ed_busy", busy_out, 0);
        tick(); chk("ed_err_c3", deq_err_out, 0);
        repeat (3) tick();
        chk("ed_no_deq", deq_count - base, 0);
        chk("ed_busy_end", busy_out, 0);

        // Contention right after an enqueue: dequeue first
        q_len_in = 4'd3;
        base = deq_count;
        des_data_in = 8'h5A;
        exp_q.push_back(8'h5A);
        des_ready_in = 1'b1;
        tick(); deq_req_in = 1'b1;
        tick(); deq_req_in = 1'b0;
        tick(); chk("ca_deq_first", q_dequeue_out, 1);
        chk("ca_no_enq", q_enqueue_out, 0);
        tick();
        tick();
        tick(); chk("ca_enq_after", q_enqueue_out, 1);
        finish_hs("ca");
        drain("ca");
        chk("ca_deq_cnt", deq_count - base, 1);

        // Plain dequeue, then contention right after a dequeue: enqueue first
        base = deq_count;
        deq_req_in = 1'b1;
        tick(); deq_req_in = 1'b0;
        wait_deq(base + 1, 10, "pd_deq");
        repeat (2) tick();
        base = deq_count;
        des_data_in = 8'hC3;
        exp_q.push_back(8'hC3);
        des_ready_in = 1'b1;
        tick(); deq_req_in = 1'b1;
        tick(); deq_req_in = 1'b0;
        tick(); chk("cb_enq_first", q_enqueue_out, 1);
        chk("cb_no_deq", q_dequeue_out, 0);
        finish_hs("cb");
        chk("cb_no_deq_in_ack", deq_count - base, 0);
        wait_deq(base + 1, 10, "cb_deq_after");
        drain("cb");

        // Merged requests during ACK
        repeat (3) tick();
        q_len_in = 4'd2;
        base = deq_count;
        des_data_in = 8'h96;
        exp_q.push_back(8'h96);
        des_ready_in = 1'b1;
        wait_ack(1'b1, 10, "mg_ack_hi");
        deq_req_in = 1'b1; tick(); deq_req_in = 1'b0; tick();
        deq_req_in = 1'b1; tick(); deq_req_in = 1'b0; tick();
        chk("mg_no_deq_in_ack", deq_count - base, 0);
        chk("mg_ack_held", des_ack_out, 1);
        des_ready_in = 1'b0;
        wait_ack(1'b0, 10, "mg_ack_lo");
        repeat (12) tick();
        chk("mg_one_deq", deq_count - base, 1);
        drain("mg");

        // Asynchronous reset while in SETTLE
        q_len_in = 4'd3;
        des_data_in = 8'h7E;
        exp_q.push_back(8'h7E);
        des_ready_in = 1'b1;
        tick(); tick();
        tick(); chk("rs_enq", q_enqueue_out, 1);
        tick(); chk("rs_settle_busy", busy_out, 1);
        chk("rs_settle_ack", des_ack_out, 0);
        #1 reset = 1'b0;
        #1;
        chk("rs_busy", busy_out, 0);
        chk("rs_ack", des_ack_out, 0);
        chk("rs_enq_low", q_enqueue_out, 0);
        chk("rs_deq_low", q_dequeue_out, 0);
        chk("rs_err", deq_err_out, 0);
        chk("rs_data", q_data_out, 8'h00);
        des_ready_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rs_post_busy", busy_out, 0);
        chk("rs_post_data", q_data_out, 8'h00);
        repeat (4) tick();
        chk("rs_post_idle", busy_out, 0);
        chk("rs_post_ack", des_ack_out, 0);
        drain("rs");

        chk("strobe_overlap", overlap_cnt, 0);
        chk("strobe_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xfer_sequencer.md
Name: xfer_sequencer

Overview:
- Controls the deserializer-to-queue path in the 10 kHz queue domain. Runs on one clock only.
- Takes finished bytes from the deserializer with a 4-phase ready/ack handshake and issues a one-cycle enqueue per byte.
- Takes user dequeue requests and serializes them against enqueues, so the queue never sees enqueue_in and dequeue_in high together.
- Replaces the ad-hoc length-change ack generation with a deterministic handshake and full/empty gating.

Parameters:
- DEPTH, 8: queue capacity in entries; full when q_len_in == DEPTH.
- LEN_W, 4: width of the queue length bus.
- SYNC_STAGES, 2: synchronizer depth for des_ready_in, which comes from the 100 kHz domain.

Ports:
- clock  in  1  queue-domain clock (10 kHz).
- reset  in  1  asynchronous, active-low reset.
- des_ready_in  in  1  deserializer byte-valid, level; held until ack is seen.
- des_data_in  in  8  deserializer byte; stable while des_ready_in is high.
- des_ack_out  out  1  handshake ack to the deserializer.
- deq_req_in  in  1  user dequeue request; one-cycle pulse.
- q_len_in  in  LEN_W  current queue length.
- q_data_out  out  8  registered byte driven to the queue data_in.
- q_enqueue_out  out  1  enqueue strobe, exactly one cycle wide.
- q_dequeue_out  out  1  dequeue strobe, exactly one cycle wide.
- full_out  out  1  q_len_in == DEPTH (combinational).
- empty_out  out  1  q_len_in == 0 (combinational).
- deq_err_out  out  1  one-cycle pulse: a dequeue request was rejected because the queue is empty.
- busy_out  out  1  FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - des_ack_out, q_enqueue_out, q_dequeue_out, deq_err_out, busy_out all 0.
  - q_data_out = 8'h00; deq_pend = 0; last_was_enq = 0; synchronizer flops = 0.
- Synchronization: rdy_s = des_ready_in after SYNC_STAGES flops. Only rdy_s is used internally.
- Request latching: deq_req_in=1 sets deq_pend in any state. deq_pend clears only when a dequeue is issued or rejected. A second request while one is pending is merged, not counted.
- FSM states: IDLE, ENQ, DEQ, SETTLE, ACK.
- IDLE transitions:
  - enq_ok = rdy_s && !full. deq_go = deq_pend.
  - enq_ok only: q_data_out <= des_data_in, go to ENQ.
  - deq_go only:
    - empty: pulse deq_err_out on the next cycle, clear deq_pend, stay in IDLE.
    - not empty: go to DEQ.
  - Both enq_ok and deq_go: round-robin.
    - last_was_enq=1: the dequeue path wins.
    - otherwise: the enqueue path wins.
  - rdy_s && full: nothing is issued, ack is withheld, and the deserializer stalls (backpressure). Dequeues are still served.
- ENQ:
  - q_enqueue_out=1 for this single cycle; last_was_enq <= 1.
  - Go to SETTLE, then ACK.
- DEQ:
  - q_dequeue_out=1 for this single cycle; last_was_enq <= 0; deq_pend <= 0.
  - Go to SETTLE, then IDLE.
- SETTLE: one cycle that lets q_len_in update. No strobes.
- ACK:
  - des_ack_out=1, held until rdy_s==0.
  - Then des_ack_out is deasserted and the FSM returns to IDLE.
  - A dequeue is never issued while in ACK.
- Latency: rdy_s rising → q_enqueue_out = 1 cycle; → des_ack_out = 3 cycles.
- Output invariants:
  - q_enqueue_out and q_dequeue_out are never both 1.
  - Each strobe is never wider than 1 cycle.
- Reset mid-operation: all state clears immediately. An in-flight byte whose enqueue was not yet issued is lost. The deserializer sees ack fall and must restart.
- Width rule: compare q_len_in against DEPTH at LEN_W bits. DEPTH must be < 2**LEN_W.

Decomposition:
- Package xfer_pkg:
  - typedef enum logic [2:0] {IDLE, ENQ, DEQ, SETTLE, ACK} xfer_state_t;
  - localparam DEPTH_DEF=8, LEN_W_DEF=4.
- Sub-module sync_ff (parameter STAGES), used for des_ready_in.

Test Plan:
- Single byte: des_data_in=8'hA5 and des_ready_in held high → q_enqueue_out pulses 1 cycle with q_data_out=8'hA5. des_ack_out rises 2 cycles later and drops 1 cycle after rdy_s falls.
- Full backpressure: q_len_in=8, ready high for 20 cycles → no enqueue and ack stays 0. Set q_len_in=7 → enqueue issues within 1 cycle.
- Empty dequeue: q_len_in=0, deq_req_in pulse → deq_err_out pulses once, q_dequeue_out stays 0, busy_out stays 0.
- Contention: ready high and deq_req pending together, q_len_in=3, last_was_enq=1 → DEQ first. After that transfer completes, the byte is enqueued. The two strobes never overlap.
- Merged requests: deq_req_in pulsed twice during ACK, q_len_in=2 → exactly one q_dequeue_out after returning to IDLE.
- Async reset asserted in SETTLE → all outputs 0 immediately with no clock edge. After release, FSM is IDLE and q_data_out=8'h00.
